rom_fetch_seq: RTL and testbench

Burst read sequencer sitting directly upstream of the ROM read port (`rom_mem`) in the cascade classifier datapath. Accepts a command (base address and length), issues a contiguous run of addresses on the ROM address channel, and forwards the returned words downstream, tagging the final one with `dout_last`. A credit counter bounds in-flight reads so ROM pipeline latency never drops or overruns data.

---
 rtl/rom_fetch_seq.sv | 217 +++++++++++++++++++++
 tb/tb_rom_fetch_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_seq.sv
// -----------------------------------------------------------------------------
// rom_fetch_seq
//
// Burst read sequencer placed directly upstream of the ROM read port. A command
// (base address, length-1) is turned into a contiguous run of ROM addresses;
// returned words are passed straight through to the downstream stream, with the
// final word of the burst tagged by dout_last. A credit counter limits the
// number of addresses accepted by the ROM without returned data, so ROM
// pipeline latency can never drop or overrun data.
//
// Ports
//   clk, rst                          : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready               : command handshake
//   cmd_addr  [W_ADDR]                : burst base address
//   cmd_len   [W_CNT]                 : burst length minus one
//   addr1_valid/addr1_ready/addr1_data: address channel to the ROM
//   data1_valid/data1_ready/data1     : data channel from the ROM
//   dout_valid/dout_ready/dout_data   : downstream stream
//   dout_last                         : marks the final word of a burst
//   busy                              : high whenever the sequencer is not idle
//   abort                             : only with ROM_FETCH_ABORT_EN
//
// Configuration
//   ROM_FETCH_ABORT_EN : when defined, adds the abort input and a FLUSH state
//                        that discards in-flight ROM words before returning
//                        to idle. When undefined every burst runs to completion.
// -----------------------------------------------------------------------------
module rom_fetch_seq #(
  parameter int unsigned W_DATA          = 8,
  parameter int unsigned W_ADDR          = 12,
  parameter int unsigned W_CNT           = 8,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic [W_CNT-1:0]  cmd_len,

  output logic              addr1_valid,
  input  logic              addr1_ready,
  output logic [W_ADDR-1:0] addr1_data,

  input  logic              data1_valid,
  output logic              data1_ready,
  input  logic [W_DATA-1:0] data1,

  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic              dout_last,

  output logic              busy
`ifdef ROM_FETCH_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned       W_OUT   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [W_OUT-1:0]  MAX_OUT = W_OUT'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
`ifdef ROM_FETCH_ABORT_EN
    ,
    S_FLUSH = 2'd3
`endif
  } state_t;

  state_t              state_q,       state_d;
  logic [W_ADDR-1:0]   cur_addr_q,    cur_addr_d;
  logic [W_CNT-1:0]    to_issue_q,    to_issue_d;
  logic [W_CNT-1:0]    to_recv_q,     to_recv_d;
  logic [W_OUT-1:0]    outstanding_q, outstanding_d;

  logic addr_hs;
  logic data_hs;
  logic dout_hs;

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, apart from the zero-latency
  // data pass-through in ISSUE/DRAIN. cmd_valid never reaches an output.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready   = 1'b0;
    addr1_valid = 1'b0;
    addr1_data  = cur_addr_q;
    data1_ready = 1'b0;
    dout_valid  = 1'b0;
    dout_data   = data1;
    dout_last   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end
      S_ISSUE: begin
        addr1_valid = (outstanding_q < MAX_OUT);
        dout_valid  = data1_valid;
        data1_ready = dout_ready;
        dout_last   = data1_valid && (to_recv_q == '0);
      end
      S_DRAIN: begin
        dout_valid  = data1_valid;
        data1_ready = dout_ready;
        dout_last   = data1_valid && (to_recv_q == '0);
      end
`ifdef ROM_FETCH_ABORT_EN
      S_FLUSH: begin
        // Accept and discard whatever the ROM still has in flight.
        data1_ready = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  assign addr_hs = addr1_valid & addr1_ready;
  assign data_hs = data1_valid & data1_ready;
  assign dout_hs = dout_valid  & dout_ready;
  assign busy    = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    to_issue_d    = to_issue_q;
    to_recv_d     = to_recv_q;
    outstanding_d = outstanding_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          to_issue_d = cmd_len;
          to_recv_d  = cmd_len;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (addr_hs) begin
          cur_addr_d = cur_addr_q + W_ADDR'(1);
          if (to_issue_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            to_issue_d = to_issue_q - W_CNT'(1);
          end
        end
      end
      S_DRAIN: begin
        if (dout_hs && dout_last) begin
          state_d = S_IDLE;
        end
      end
`ifdef ROM_FETCH_ABORT_EN
      S_FLUSH: begin
        if (outstanding_q == '0) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The final beat leaves to_recv at zero rather than wrapping it.
    if (dout_hs && (to_recv_q != '0)) begin
      to_recv_d = to_recv_q - W_CNT'(1);
    end

    // Credit counter: saturating at both ends so a misbehaving ROM cannot
    // corrupt it; simultaneous issue and return leave it unchanged.
    case ({addr_hs, data_hs})
      2'b10: if (outstanding_q != MAX_OUT) outstanding_d = outstanding_q + W_OUT'(1);
      2'b01: if (outstanding_q != '0)      outstanding_d = outstanding_q - W_OUT'(1);
      default: begin
      end
    endcase

`ifdef ROM_FETCH_ABORT_EN
    // Abort overrides the burst transitions; credit bookkeeping above still
    // records any handshake taken in the same cycle.
    if (abort && ((state_q == S_ISSUE) || (state_q == S_DRAIN))) begin
      state_d = S_FLUSH;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_addr_q    <= '0;
      to_issue_q    <= '0;
      to_recv_q     <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      to_issue_q    <= to_issue_d;
      to_recv_q     <= to_recv_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_rom_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_rom_fetch_seq
//
// Directed bench for rom_fetch_seq. Stimulus pushes the expected address run
// and expected downstream beats into queues; a negedge monitor pops and
// compares on every address and dout handshake. A one-cycle-latency ROM model
// answers address handshakes with a known word per address.
// -----------------------------------------------------------------------------
module tb_rom_fetch_seq;

  localparam int unsigned W_DATA = 8;
  localparam int unsigned W_ADDR = 12;
  localparam int unsigned W_CNT  = 8;
  localparam int unsigned MAX_OS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [W_ADDR-1:0] cmd_addr;
  logic [W_CNT-1:0]  cmd_len;
  logic              addr1_valid;
  logic              addr1_ready;
  logic [W_ADDR-1:0] addr1_data;
  logic              data1_valid = 1'b0;
  logic              data1_ready;
  logic [W_DATA-1:0] data1 = '0;
  logic              dout_valid;
  logic              dout_ready;
  logic [W_DATA-1:0] dout_data;
  logic              dout_last;
  logic              busy;
`ifdef ROM_FETCH_ABORT_EN
  logic              abort;
`endif

  always #5 clk = ~clk;

  rom_fetch_seq #(
    .W_DATA          (W_DATA),
    .W_ADDR          (W_ADDR),
    .W_CNT           (W_CNT),
    .MAX_OUTSTANDING (MAX_OS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .addr1_valid (addr1_valid),
    .addr1_ready (addr1_ready),
    .addr1_data  (addr1_data),
    .data1_valid (data1_valid),
    .data1_ready (data1_ready),
    .data1       (data1),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_last   (dout_last),
    .busy        (busy)
`ifdef ROM_FETCH_ABORT_EN
    ,
    .abort       (abort)
`endif
  );

  int checks = 0;
  int errors = 0;
  int addr_cnt = 0;
  int beat_cnt = 0;

  logic [W_ADDR-1:0] exp_addr_q[$];
  logic [W_DATA:0]   exp_beat_q[$];   // {last, data}
  logic [W_ADDR-1:0] rom_q[$];

  logic              a_hs_s = 1'b0;
  logic              d_hs_s = 1'b0;
  logic [W_ADDR-1:0] a_s    = '0;

  function automatic logic [W_DATA-1:0] rom_word(input logic [W_ADDR-1:0] a);
    return a[7:0] ^ {4'hA, a[11:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshake values are stable from negedge to the next posedge.
  always @(negedge clk) begin
    a_hs_s = addr1_valid && addr1_ready;
    d_hs_s = data1_valid && data1_ready;
    a_s    = addr1_data;
    if (!rst) begin
      if (a_hs_s) begin
        addr_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL addr_extra: got %0h expected no transfer", addr1_data);
        end else begin
          check("addr", 32'(addr1_data), 32'(exp_addr_q.pop_front()));
        end
      end
      if (dout_valid && dout_ready) begin
        beat_cnt++;
        if (exp_beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_extra: got %0h last %0b expected no transfer", dout_data, dout_last);
        end else begin
          check("beat", 32'({dout_last, dout_data}), 32'(exp_beat_q.pop_front()));
        end
      end
    end
  end

  // ROM model: one cycle from address acceptance to data presentation.
  always @(posedge clk) begin
    logic [W_ADDR-1:0] dummy;
    if (rst) begin
      rom_q.delete();
    end else begin
      if (d_hs_s && (rom_q.size() != 0)) dummy = rom_q.pop_front();
      if (a_hs_s) rom_q.push_back(a_s);
    end
    #1;
    data1_valid = (rom_q.size() != 0);
    data1       = (rom_q.size() != 0) ? rom_word(rom_q[0]) : '0;
  end

  task automatic send_cmd(input logic [W_ADDR-1:0] a, input logic [W_CNT-1:0] l);
    logic ok;
    for (int i = 0; i <= int'(l); i++) begin
      logic [W_ADDR-1:0] ad;
      ad = a + W_ADDR'(i);
      exp_addr_q.push_back(ad);
      exp_beat_q.push_back({(i == int'(l)), rom_word(ad)});
    end
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got no handshake expected one within 50 cycles");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy && (exp_beat_q.size() == 0) && (exp_addr_q.size() == 0)) begin
        ok = 1'b0 | 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle: got busy %0b pending addr %0d beats %0d expected idle and drained",
               name, busy, exp_addr_q.size(), exp_beat_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int b0;
    logic hit;

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    addr1_ready = 1'b1;
    dout_ready  = 1'b1;
`ifdef ROM_FETCH_ABORT_EN
    abort       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
    check("rst_addr1_valid", 32'(addr1_valid), 32'd0);
    check("rst_data1_ready", 32'(data1_ready), 32'd0);
    check("rst_dout_valid",  32'(dout_valid),  32'd0);
    check("rst_dout_last",   32'(dout_last),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);

    // Basic burst: four addresses in consecutive cycles right after accept
    @(posedge clk);
    #1;
    send_cmd(12'h010, 8'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_issue_consec", 32'({addr1_valid, addr1_ready}), 32'h3);
    end
    wait_idle("t1");
    check("t1_busy_after",      32'(busy),      32'd0);
    check("t1_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // Address wrap at the top of the ROM
    @(posedge clk);
    #1;
    a0 = addr_cnt;
    send_cmd(12'hFFE, 8'd3);
    wait_idle("t2");
    check("t2_addr_count", 32'(addr_cnt - a0), 32'd4);

    // Single-word burst
    @(posedge clk);
    #1;
    a0 = addr_cnt;
    b0 = beat_cnt;
    send_cmd(12'h0A5, 8'd0);
    wait_idle("t3");
    check("t3_addr_count", 32'(addr_cnt - a0), 32'd1);
    check("t3_beat_count", 32'(beat_cnt - b0), 32'd1);

    // Downstream stall: credits cap in-flight addresses at MAX_OUTSTANDING
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    a0 = addr_cnt;
    b0 = beat_cnt;
    send_cmd(12'h200, 8'd7);
    repeat (8) @(negedge clk);
    check("t4_addr_capped",   32'(addr_cnt - a0), 32'd2);
    check("t4_addr_valid_lo", 32'(addr1_valid),   32'd0);
    check("t4_dout_held",     32'({dout_valid, dout_data}), 32'({1'b1, rom_word(12'h200)}));
    @(posedge clk);
    #1 dout_ready = 1'b1;
    wait_idle("t4");
    check("t4_addr_count", 32'(addr_cnt - a0), 32'd8);
    check("t4_beat_count", 32'(beat_cnt - b0), 32'd8);

    // Reset mid-burst after the second beat
    @(posedge clk);
    #1;
    b0 = beat_cnt;
    send_cmd(12'h300, 8'd7);
    hit = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (beat_cnt >= b0 + 2) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL t5_two_beats: got %0d beats expected 2", beat_cnt - b0);
    end
    #1 rst = 1'b1;
    exp_addr_q.delete();
    exp_beat_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_busy",        32'(busy),        32'd0);
    check("t5_cmd_ready",   32'(cmd_ready),   32'd1);
    check("t5_addr1_valid", 32'(addr1_valid), 32'd0);
    check("t5_dout_valid",  32'(dout_valid),  32'd0);
    check("t5_beats_total", 32'(beat_cnt - b0), 32'd2);
    @(posedge clk);
    #1;
    send_cmd(12'h123, 8'd2);
    wait_idle("t5_after");

`ifdef ROM_FETCH_ABORT_EN
    // Abort with three addresses issued and one beat delivered
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    a0 = addr_cnt;
    b0 = beat_cnt;
    send_cmd(12'h400, 8'd7);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 dout_ready = 1'b1;
    @(posedge clk);
    #1 dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_addr_before", 32'(addr_cnt - a0), 32'd3);
    check("t6_beat_before", 32'(beat_cnt - b0), 32'd1);
    @(posedge clk);
    #1 abort = 1'b1;
    exp_addr_q.delete();
    exp_beat_q.delete();
    @(posedge clk);
    #1 abort = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!busy) begin
        hit = 1'b1;
        break;
      end
      check("t6_flush_quiet", 32'({addr1_valid, dout_valid}), 32'd0);
    end
    check("t6_flush_done",  32'(hit),              32'd1);
    check("t6_addr_after",  32'(addr_cnt - a0),    32'd3);
    check("t6_beat_after",  32'(beat_cnt - b0),    32'd1);
    check("t6_rom_drained", 32'(rom_q.size()),     32'd0);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t6_abort_idle_ignored", 32'({busy, cmd_ready}), 32'h1);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    send_cmd(12'h500, 8'd1);
    wait_idle("t6_after");
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
